// File: rtl/fir_mac_sched.sv
// fir_mac_sched: time-multiplexed FIR controller. One shared signed MAC is
// stepped across all taps for every accepted sample. A circular history
// buffer holds the last TAPS samples. Coefficients are double-banked: a
// shadow bank that software writes freely, and an active bank that only
// changes between samples.
module fir_mac_sched #(
    parameter int TAPS = 16,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DW-1:0]           in_data,
    output logic                    in_ready,
    input  logic                    cfg_we,
    input  logic [$clog2(TAPS)-1:0] cfg_addr,
    input  logic [CW-1:0]           cfg_data,
    input  logic                    cfg_commit,
    output logic                    commit_pend,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic                    out_sat
);

    localparam int AW   = $clog2(TAPS);
    localparam int PW   = DW + CW;
    localparam int ACCW = PW + AW;

    // Clamp limits for the output, expressed at accumulator width so the
    // comparison sees every guard bit.
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [AW-1:0]          wp;
    logic [AW-1:0]          k;
    logic [AW-1:0]          rd_idx;
    logic signed [DW-1:0]   hist     [TAPS];
    logic signed [CW-1:0]   coef_sh  [TAPS];
    logic signed [CW-1:0]   coef_act [TAPS];
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] shifted;
    logic signed [PW-1:0]   prod;
    logic                   accept;
    logic                   last_tap;
    logic                   apply_commit;
    logic [DW-1:0]          sat_data;
    logic                   sat_flag;

    assign accept       = in_valid && (state == IDLE);
    assign last_tap     = (state == MAC) && (k == AW'(TAPS - 1));
    assign apply_commit = commit_pend && (state == IDLE);

    // wp already points past the newest sample, so newest is wp-1 and the
    // tap-k sample is k entries older; AW-bit arithmetic wraps the ring.
    assign rd_idx = wp - AW'(1) - k;

    // Full-precision product; the size casts sign-extend before multiplying
    // so no product bits are lost.
    assign prod = PW'(coef_act[k]) * PW'(hist[rd_idx]);

    // Tap 0 restarts the accumulation, later taps add onto it. The extra AW
    // guard bits mean the sum of TAPS full-scale products cannot wrap.
    assign sum     = (k == '0) ? ACCW'(prod) : acc + ACCW'(prod);
    assign shifted = sum >>> FRAC;

    // Saturate the rescaled sum to the output width and flag when clamped.
    always_comb begin
        sat_data = shifted[DW-1:0];
        sat_flag = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_data = {1'b0, {(DW-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_data = {1'b1, {(DW-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one MAC cycle per tap, then a single DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = MAC;
            MAC:     if (last_tap) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Sample capture into the ring, tap counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            k   <= '0;
            acc <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
        end else begin
            if (accept) begin
                hist[wp] <= $signed(in_data);
                wp       <= wp + AW'(1);
                k        <= '0;
            end
            if (state == MAC) begin
                acc <= sum;
                k   <= k + AW'(1);
            end
        end
    end

    // The final sum is complete on the last tap edge, so the result is
    // registered there and is already stable throughout the DONE cycle;
    // it then holds until the next sample finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (last_tap) begin
            out_data <= sat_data;
            out_sat  <= sat_flag;
        end
    end

    // Coefficient banks: the shadow takes writes at any time, and the active
    // bank is refreshed only on an IDLE edge with a commit pending, so a
    // running computation never sees a mix of old and new taps. A shadow
    // write on the copy edge is forwarded so it is part of the new bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pend <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef_sh[i]  <= '0;
                coef_act[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                coef_sh[cfg_addr] <= $signed(cfg_data);
            end
            if (apply_commit) begin
                for (int i = 0; i < TAPS; i++) begin
                    coef_act[i] <= (cfg_we && (cfg_addr == AW'(i))) ? $signed(cfg_data) : coef_sh[i];
                end
            end
            if (cfg_commit) begin
                commit_pend <= 1'b1;
            end else if (apply_commit) begin
                commit_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: randomized and directed scenarios for fir_mac_sched,
// checked against a newest-first history / coefficient-array reference model.
module tb_fir_mac_sched;

    localparam int TAPS = 16;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int FRAC = 11;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_commit;
    logic          commit_pend;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sat;

    int errors = 0;
    int checks = 0;

    int                 mcoef [TAPS];
    logic signed [15:0] mhist [TAPS];
    int                 stage_coef [TAPS];

    fir_mac_sched #(.TAPS(TAPS), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .commit_pend(commit_pend),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Run-away guard.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_clear();
        for (int i = 0; i < TAPS; i++) begin
            mcoef[i] = 0;
            mhist[i] = '0;
        end
    endfunction

    function automatic void model_push(input logic [15:0] x);
        for (int i = TAPS - 1; i > 0; i--) mhist[i] = mhist[i-1];
        mhist[0] = x;
    endfunction

    // y = floor(sum(c[i] * x[n-i]) / 2^FRAC), clamped to 16-bit signed.
    function automatic void model_eval(output logic [15:0] d, output logic s);
        longint a = 0;
        for (int i = 0; i < TAPS; i++) a += longint'(mcoef[i]) * longint'(mhist[i]);
        a = a >>> FRAC;
        if (a > 32767) begin
            d = 16'h7fff; s = 1'b1;
        end else if (a < -32768) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = 16'(a); s = 1'b0;
        end
    endfunction

    // Writes stage_coef to the shadow bank, committing with the last write,
    // and reports commit_pend right after the commit and one IDLE edge later.
    task automatic load_coefs(output logic pend_set, output logic pend_clr);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin @(negedge clk); n++; end
        for (int i = 0; i < TAPS; i++) begin
            cfg_we     = 1'b1;
            cfg_addr   = AW'(i);
            cfg_data   = 16'(stage_coef[i]);
            cfg_commit = (i == TAPS - 1);
            @(negedge clk);
        end
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        pend_set   = commit_pend;
        @(negedge clk);
        pend_clr = commit_pend;
        for (int i = 0; i < TAPS; i++) mcoef[i] = stage_coef[i];
    endtask

    // Offers one sample, waits for its result and returns observed vs model.
    task automatic apply_sample(input logic [15:0] x, output logic [15:0] got_d, output logic got_s,
                                output int lat, output logic [15:0] exp_d, output logic exp_s);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin @(negedge clk); n++; end
        model_push(x);
        model_eval(exp_d, exp_s);
        if (!in_ready) begin
            lat = -1; got_d = 'x; got_s = 1'bx;
            return;
        end
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
        got_d = out_data;
        got_s = out_sat;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0000", out_data); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_sat: got %b want 0", out_sat); end
        checks++; if (commit_pend !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit_pend: got %b want 0", commit_pend); end
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        logic p1, p2, gs, es;
        logic [15:0] gd, ed;
        int lat;
        for (int i = 0; i < TAPS; i++) stage_coef[i] = i + 1;
        load_coefs(p1, p2);
        checks++; if (p1 !== 1'b1) begin errors++; $display("[TB] FAIL commit_pend_set: got %b want 1", p1); end
        checks++; if (p2 !== 1'b0) begin errors++; $display("[TB] FAIL commit_pend_clear: got %b want 0", p2); end
        for (int i = 0; i < TAPS; i++) begin
            apply_sample((i == 0) ? 16'h0800 : 16'h0000, gd, gs, lat, ed, es);
            checks++; if (gd !== 16'(i + 1)) begin errors++; $display("[TB] FAIL impulse_tap%0d: got %0d want %0d", i, gd, i + 1); end
            checks++; if (gd !== ed) begin errors++; $display("[TB] FAIL impulse_model%0d: got %h want %h", i, gd, ed); end
            checks++; if (gs !== 1'b0) begin errors++; $display("[TB] FAIL impulse_sat%0d: got %b want 0", i, gs); end
            checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL impulse_latency%0d: got %0d want 17", i, lat); end
        end
    endtask

    task automatic test_dc();
        int lp [TAPS] = '{-9, -11, -10, 18, 90, 205, 327, 407, 407, 327, 205, 90, 18, -10, -11, -9};
        logic p1, p2, gs, es;
        logic [15:0] gd, ed;
        int lat;
        for (int i = 0; i < TAPS; i++) stage_coef[i] = lp[i];
        load_coefs(p1, p2);
        for (int i = 0; i < 32; i++) begin
            apply_sample(16'h1000, gd, gs, lat, ed, es);
            checks++; if (gd !== ed || gs !== es) begin errors++; $display("[TB] FAIL dc_model%0d: got %h/%b want %h/%b", i, gd, gs, ed, es); end
        end
        checks++; if (gd !== 16'd4068 || gs !== 1'b0) begin errors++; $display("[TB] FAIL dc_steady: got %0d/%b want 4068/0", gd, gs); end
    endtask

    task automatic test_saturation();
        logic p1, p2, gs, es;
        logic [15:0] gd, ed;
        int lat;
        for (int i = 0; i < TAPS; i++) stage_coef[i] = 32767;
        load_coefs(p1, p2);
        for (int i = 0; i < 2 * TAPS; i++) begin
            apply_sample((i < TAPS) ? 16'h7fff : 16'h8000, gd, gs, lat, ed, es);
            checks++; if (gd !== ed || gs !== es) begin errors++; $display("[TB] FAIL sat_model%0d: got %h/%b want %h/%b", i, gd, gs, ed, es); end
            if (i == TAPS - 1) begin
                checks++; if (gd !== 16'h7fff || gs !== 1'b1) begin errors++; $display("[TB] FAIL sat_pos: got %h/%b want 7fff/1", gd, gs); end
            end
        end
        checks++; if (gd !== 16'h8000 || gs !== 1'b1) begin errors++; $display("[TB] FAIL sat_neg: got %h/%b want 8000/1", gd, gs); end
    endtask

    task automatic test_random();
        logic p1, p2, gs, es;
        logic [15:0] gd, ed;
        int lat;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < TAPS; i++) begin
                if (r == 0) stage_coef[i] = int'($urandom_range(0, 65535)) - 32768;
                else        stage_coef[i] = int'($urandom_range(0, 2047)) - 1024;
            end
            load_coefs(p1, p2);
            for (int i = 0; i < 12; i++) begin
                apply_sample(16'($urandom), gd, gs, lat, ed, es);
                checks++; if (gd !== ed || gs !== es) begin errors++; $display("[TB] FAIL random_r%0d_s%0d: got %h/%b want %h/%b", r, i, gd, gs, ed, es); end
            end
        end
    endtask

    task automatic test_commit_during_mac();
        int bvals [TAPS];
        logic p1, p2;
        logic [15:0] ea, eb, x, y;
        logic sa, sb;
        int n;
        for (int i = 0; i < TAPS; i++) stage_coef[i] = int'($urandom_range(0, 4095)) - 2048;
        load_coefs(p1, p2);
        // New bank goes to the shadow only; the active bank must not move.
        for (int i = 0; i < TAPS; i++) begin
            bvals[i] = int'($urandom_range(0, 4095)) - 2048;
            cfg_we = 1'b1; cfg_addr = AW'(i); cfg_data = 16'(bvals[i]);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        checks++; if (commit_pend !== 1'b0) begin errors++; $display("[TB] FAIL shadow_no_pend: got %b want 0", commit_pend); end
        x = 16'($urandom);
        in_valid = 1'b1; in_data = x;
        model_push(x); model_eval(ea, sa);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        bvals[3] = int'($urandom_range(0, 4095)) - 2048;
        cfg_we = 1'b1; cfg_addr = AW'(3); cfg_data = 16'(bvals[3]); cfg_commit = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; cfg_commit = 1'b0;
        checks++; if (commit_pend !== 1'b1) begin errors++; $display("[TB] FAIL mac_pend_set: got %b want 1", commit_pend); end
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mac_old_timeout: got %b want 1", out_valid); end
        checks++; if (commit_pend !== 1'b1) begin errors++; $display("[TB] FAIL done_pend_held: got %b want 1", commit_pend); end
        checks++; if (out_data !== ea || out_sat !== sa) begin errors++; $display("[TB] FAIL mac_old_bank: got %h/%b want %h/%b", out_data, out_sat, ea, sa); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || commit_pend !== 1'b1) begin errors++; $display("[TB] FAIL idle_pend: got ready=%b pend=%b want 1/1", in_ready, commit_pend); end
        // Accept on the same IDLE edge that applies the commit.
        y = 16'($urandom);
        in_valid = 1'b1; in_data = y;
        for (int i = 0; i < TAPS; i++) mcoef[i] = bvals[i];
        model_push(y); model_eval(eb, sb);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (commit_pend !== 1'b0) begin errors++; $display("[TB] FAIL pend_applied: got %b want 0", commit_pend); end
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (out_data !== eb || out_sat !== sb) begin errors++; $display("[TB] FAIL mac_new_bank: got %h/%b want %h/%b", out_data, out_sat, eb, sb); end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int outs = 0;
        int last_acc = -1;
        logic [15:0] pe;
        logic ps;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 140; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                outs++;
                checks++; if (out_data !== pe || out_sat !== ps) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h/%b want %h/%b", outs, out_data, out_sat, pe, ps); end
            end
            if (accepts < 6) begin
                in_data = 16'($urandom);
                if (in_ready) begin
                    model_push(in_data);
                    model_eval(pe, ps);
                    if (last_acc >= 0) begin
                        checks++; if (cyc - last_acc !== 18) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d want 18", cyc - last_acc); end
                    end
                    last_acc = cyc;
                    accepts++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++; if (outs !== accepts || accepts !== 6) begin errors++; $display("[TB] FAIL b2b_count: got outs=%0d accepts=%0d want 6/6", outs, accepts); end
    endtask

    task automatic test_reset_mid();
        logic p1, p2, gs, es, seen;
        logic [15:0] gd, ed;
        int lat;
        for (int i = 0; i < TAPS; i++) stage_coef[i] = i + 1;
        load_coefs(p1, p2);
        for (int i = 0; i < 4; i++) apply_sample(16'($urandom_range(4096, 16383)), gd, gs, lat, ed, es);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_hs: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        checks++; if (out_data !== 16'h0000 || out_sat !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out: got %h/%b want 0000/0", out_data, out_sat); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_valid: got %b want 0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b want 1", in_ready); end
        model_clear();
        load_coefs(p1, p2);
        for (int i = 0; i < 4; i++) begin
            apply_sample((i == 0) ? 16'h0800 : 16'h0000, gd, gs, lat, ed, es);
            checks++; if (gd !== 16'(i + 1) || gd !== ed) begin errors++; $display("[TB] FAIL rstmid_impulse%0d: got %0d want %0d", i, gd, i + 1); end
            checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL rstmid_latency%0d: got %0d want 17", i, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_saturation();
        test_random();
        test_commit_during_mac();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
